sram_ctrl: RTL
==============

Name: sram_ctrl

Overview:
- Burst initiator that owns the requester side of the team's single-port SRAM interface: dataIn/dataOut/Addr/WE/RD, with the memory sampling on the rising clock edge.
- Accepts one burst request at a time (start address, length, direction) over a valid/ready handshake.
- Streams write beats in, or read beats out, issuing one SRAM access per beat.
- Sits between a CPU/datapath client and the SRAM instance; the SRAM never sees WE and RD high together.

Parameters:
ADR, 8, SRAM address width
DAT, 8, data width
DPTH, 8, number of SRAM words; legal addresses are 0..DPTH-1, DPTH <= 2**ADR
LENW, 4, burst-length field width; beats = req_len+1 (1..2**LENW)

Ports:
Clk  in  1  clock, rising edge
Rst  in  1  reset, asynchronous, active-high
req_valid  in  1  burst request present
req_ready  out  1  controller can accept a request
req_write  in  1  1 = write burst, 0 = read burst
req_addr  in  ADR  start address
req_len  in  LENW  beats minus one
wr_valid  in  1  write beat data present
wr_ready  out  1  controller accepts write beat
wr_data  in  DAT  write beat data
rd_valid  out  1  rd_data valid this cycle (no backpressure)
rd_data  out  DAT  read beat data
done  out  1  one-cycle pulse, burst complete
err  out  1  one-cycle pulse, request rejected
sram_dataIn  out  DAT  to SRAM dataIn
sram_dataOut  in  DAT  from SRAM dataOut
sram_Addr  out  ADR  to SRAM Addr
sram_WE  out  1  to SRAM WE
sram_RD  out  1  to SRAM RD

Behaviour:
- Reset (async, while Rst=1):
  - State IDLE; registered req_ready=1.
  - sram_WE, sram_RD, rd_valid, done and err are 0; sram_Addr, sram_dataIn and rd_data are 0.
  - Read pipeline valids are cleared.
- Reset mid-burst: the access is abandoned immediately (WE/RD drop asynchronously), in-flight read data is discarded, and no done pulse is produced.
- All outputs are registered except wr_ready, which is combinational: (state==WR).
- States: IDLE, WR, RD, DRAIN.
- IDLE:
  - req_ready=1. Handshake at the edge where req_valid & req_ready.
  - If req_addr >= DPTH: err=1 for the next cycle, stay in IDLE, no SRAM access.
  - Otherwise load cur_addr=req_addr and beats_left=req_len, then go to WR (req_write=1) or RD (req_write=0). req_ready=0 in all other states.
- WR:
  - Each wr_valid & wr_ready edge registers sram_WE=1, sram_RD=0, sram_Addr=cur_addr, sram_dataIn=wr_data for the following cycle. The SRAM writes at the end of that cycle.
  - A cycle with wr_valid=0 drives sram_WE=0 (bubble, no write).
  - On the last beat (beats_left==0), go to IDLE; done=1 in the same cycle the final sram_WE=1 is presented.
- RD:
  - Each cycle registers sram_RD=1, sram_WE=0, sram_Addr=cur_addr.
  - Per beat: if RD is asserted in cycle k, the SRAM updates dataOut at the end of k, the controller samples sram_dataOut at the end of k+1, and rd_valid=1 with rd_data in cycle k+2. Read latency is 2 cycles from sram_RD to rd_valid.
  - After issuing the last beat, go to DRAIN with sram_RD=0.
- DRAIN: wait until the 2-stage valid pipeline is empty. done=1 in the same cycle as the final rd_valid, then go to IDLE.
- Address advance: after every issued access, cur_addr = (cur_addr==DPTH-1) ? 0 : cur_addr+1. Wrap is at DPTH, not 2**ADR.
- Beat counter: beats_left decrements per issued access; the burst ends when an access is issued with beats_left==0.
- Idle cycles: sram_WE=sram_RD=0, and sram_Addr/sram_dataIn hold their last values.
- Back-to-back requests: the earliest next acceptance is the cycle after done. Throughput is 1 beat/cycle with no stalls.

Test Plan:
- Reset: assert Rst mid-cycle -> sram_WE=sram_RD=0 and req_ready=1 immediately; rd_valid, done and err stay 0 after release.
- Write burst: addr=2, len=3, data 0xA1,0xA2,0xA3,0xA4 with wr_valid constant -> SRAM addrs 2..5 hold those values; sram_WE high 4 consecutive cycles; done coincides with the 4th WE.
- Read burst: addr=2, len=3 after the previous test -> rd_valid for 4 consecutive cycles, starting 2 cycles after the first sram_RD, with rd_data 0xA1..0xA4; done with the last beat; WE never high.
- Wrap: DPTH=8, write addr=6, len=3, data 1,2,3,4 -> addrs 6,7,0,1 written; reading back addr=6 len=3 returns 1,2,3,4.
- Write stall: wr_valid deasserted 2 cycles between beats 1 and 2 -> sram_WE=0 during the gap; only 2 writes total for len=1; done with the second WE.
- Illegal address: DPTH=8, req_addr=9 -> err pulse 1 cycle, no WE/RD activity, req_ready stays 1; a subsequent legal request is accepted normally.

Source files
------------

// File: rtl/sram_ctrl.sv
// Burst initiator on the requester side of a single-port SRAM: takes one
// address/length/direction request at a time and issues one SRAM access per beat.
module sram_ctrl #(
  parameter int ADR  = 8,
  parameter int DAT  = 8,
  parameter int DPTH = 8,
  parameter int LENW = 4
) (
  input  logic            Clk,
  input  logic            Rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_write,
  input  logic [ADR-1:0]  req_addr,
  input  logic [LENW-1:0] req_len,
  input  logic            wr_valid,
  output logic            wr_ready,
  input  logic [DAT-1:0]  wr_data,
  output logic            rd_valid,
  output logic [DAT-1:0]  rd_data,
  output logic            done,
  output logic            err,
  output logic [DAT-1:0]  sram_dataIn,
  input  logic [DAT-1:0]  sram_dataOut,
  output logic [ADR-1:0]  sram_Addr,
  output logic            sram_WE,
  output logic            sram_RD
);

  typedef enum logic [1:0] {IDLE, WR, RD, DRAIN} state_t;

  localparam logic [ADR:0]   DPTH_X    = (ADR+1)'(DPTH);
  localparam logic [ADR-1:0] LAST_ADDR = ADR'(DPTH - 1);

  state_t          state, state_nxt;
  logic [ADR-1:0]  cur_addr, cur_addr_nxt, addr_inc;
  logic [LENW-1:0] beats_left, beats_nxt;
  logic            rd_pipe;
  logic            we_nxt, rd_nxt, done_nxt, err_nxt;
  logic [ADR-1:0]  addr_nxt;
  logic [DAT-1:0]  din_nxt;
  logic            req_fire, req_bad, wr_fire, drain_done;

  assign req_fire   = req_valid & req_ready;
  assign req_bad    = {1'b0, req_addr} >= DPTH_X;
  assign wr_ready   = (state == WR);
  assign wr_fire    = wr_valid & wr_ready;
  // Wrap at the real memory depth, not at the address-bus limit.
  assign addr_inc   = (cur_addr == LAST_ADDR) ? '0 : cur_addr + 1'b1;
  // Last read beat sits in stage one with nothing behind it.
  assign drain_done = (state == DRAIN) & rd_pipe & ~sram_RD;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_fire && !req_bad) state_nxt = req_write ? WR : RD;
      WR:      if (wr_fire && beats_left == '0) state_nxt = IDLE;
      RD:      if (beats_left == '0) state_nxt = DRAIN;
      DRAIN:   if (drain_done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    we_nxt       = 1'b0;
    rd_nxt       = 1'b0;
    done_nxt     = 1'b0;
    err_nxt      = 1'b0;
    addr_nxt     = sram_Addr;
    din_nxt      = sram_dataIn;
    cur_addr_nxt = cur_addr;
    beats_nxt    = beats_left;
    case (state)
      IDLE: begin
        if (req_fire) begin
          if (req_bad) begin
            err_nxt = 1'b1;
          end else begin
            cur_addr_nxt = req_addr;
            beats_nxt    = req_len;
          end
        end
      end
      WR: begin
        if (wr_fire) begin
          we_nxt       = 1'b1;
          addr_nxt     = cur_addr;
          din_nxt      = wr_data;
          cur_addr_nxt = addr_inc;
          beats_nxt    = beats_left - 1'b1;
          done_nxt     = (beats_left == '0);
        end
      end
      RD: begin
        rd_nxt       = 1'b1;
        addr_nxt     = cur_addr;
        cur_addr_nxt = addr_inc;
        beats_nxt    = beats_left - 1'b1;
      end
      DRAIN:   done_nxt = drain_done;
      default: ;
    endcase
  end

  // Every output except wr_ready is registered; reset drops the SRAM strobes at once.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      req_ready   <= 1'b1;
      sram_WE     <= 1'b0;
      sram_RD     <= 1'b0;
      sram_Addr   <= '0;
      sram_dataIn <= '0;
      done        <= 1'b0;
      err         <= 1'b0;
      cur_addr    <= '0;
      beats_left  <= '0;
      rd_pipe     <= 1'b0;
      rd_valid    <= 1'b0;
      rd_data     <= '0;
    end else begin
      req_ready   <= (state_nxt == IDLE);
      sram_WE     <= we_nxt;
      sram_RD     <= rd_nxt;
      sram_Addr   <= addr_nxt;
      sram_dataIn <= din_nxt;
      done        <= done_nxt;
      err         <= err_nxt;
      cur_addr    <= cur_addr_nxt;
      beats_left  <= beats_nxt;
      rd_pipe     <= sram_RD;
      rd_valid    <= rd_pipe;
      if (rd_pipe) rd_data <= sram_dataOut;
    end
  end

endmodule
